// File: rtl/hamming_encoder_seq.sv
// Iterative 32->38 bit Hamming encoder: scatters data on accept, then folds one
// codeword position per cycle into the parity accumulator before presenting the codeword.
module hamming_encoder_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [37:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [5:0] LAST_POS = 6'd38;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [37:0] cw_q, cw_d;
    logic [37:0] out_q, out_d;
    logic [5:0]  p_q, p_d;
    logic [5:0]  pos_q, pos_d;

    logic [37:0] scattered;
    logic [5:0]  bit_idx;
    logic [5:0]  p_step;
    logic [37:0] with_parity;

    // Data occupies every non-power-of-two position, in ascending order.
    always_comb begin
        scattered        = '0;
        scattered[2]     = in_data[0];
        scattered[6:4]   = in_data[3:1];
        scattered[14:8]  = in_data[10:4];
        scattered[30:16] = in_data[25:11];
        scattered[37:32] = in_data[31:26];
    end

    assign bit_idx = pos_q - 6'd1;
    assign p_step  = cw_q[bit_idx] ? (p_q ^ pos_q) : p_q;

    always_comb begin
        with_parity     = cw_q;
        with_parity[0]  = p_step[0];
        with_parity[1]  = p_step[1];
        with_parity[3]  = p_step[2];
        with_parity[7]  = p_step[3];
        with_parity[15] = p_step[4];
        with_parity[31] = p_step[5];
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        out_d   = out_q;
        p_d     = p_q;
        pos_d   = pos_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cw_d    = scattered;
                    p_d     = '0;
                    pos_d   = 6'd1;
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d = p_step;
                if (pos_q == LAST_POS) begin
                    out_d   = with_parity;
                    state_d = DONE;
                end else begin
                    pos_d = pos_q + 6'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cw_q    <= '0;
            out_q   <= '0;
            p_q     <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            out_q   <= out_d;
            p_q     <= p_d;
            pos_q   <= pos_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_hamming_encoder_seq.sv
// Directed and loopback bench for hamming_encoder_seq: checks codewords, latency,
// backpressure, async reset and single-error correction against a reference model.
module tb_hamming_encoder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    hamming_encoder_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] model(input logic [31:0] d);
        logic [37:0] cw = '0;
        logic [5:0]  p  = '0;
        int          k  = 0;
        for (int j = 1; j <= 38; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j-1] = d[k];
                if (d[k]) p ^= j[5:0];
                k++;
            end
        end
        for (int i = 0; i < 6; i++) cw[(1 << i) - 1] = p[i];
        return cw;
    endfunction

    function automatic logic [5:0] syndrome(input logic [37:0] cw);
        logic [5:0] s = '0;
        for (int j = 1; j <= 38; j++) if (cw[j-1]) s ^= j[5:0];
        return s;
    endfunction

    task automatic accept(input logic [31:0] d);
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
        end
        check("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic run_directed(input string tag, input logic [31:0] d, input logic [37:0] exp);
        int cyc;
        out_ready = 1'b0;
        accept(d);
        check({tag, "_in_ready_low"}, in_ready, 1'b0);
        check({tag, "_busy_high"}, busy, 1'b1);
        wait_valid(cyc);
        check({tag, "_latency"}, cyc, 38);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_syndrome"}, syndrome(out_data), 6'd0);
        out_ready = 1'b1;
        step();
        check({tag, "_valid_drop"}, out_valid, 1'b0);
        check({tag, "_ready_back"}, in_ready, 1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [37:0] held;
        logic [37:0] exp;
        logic [37:0] flipped;
        logic [37:0] corrected;
        logic [5:0]  s;
        int          fpos;

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 38'h0);
        step();
        step();
        rst = 1'b0;
        step();

        run_directed("zero", 32'h0000_0000, 38'h00_0000_0000);
        run_directed("one", 32'h0000_0001, 38'h00_0000_0007);
        run_directed("msb", 32'h8000_0000, 38'h20_8000_000A);
        run_directed("ones", 32'hFFFF_FFFF, 38'h3F_7FFF_FFF4);

        // Backpressure, with in_valid noise during CALC and DONE.
        accept(32'h8000_0000);
        for (int i = 0; i < 10; i++) step();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        check("bp_calc_busy", busy, 1'b1);
        wait_valid(cyc);
        held = out_data;
        check("bp_first", held, 38'h20_8000_000A);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_data", out_data, 38'h20_8000_000A);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_ready", in_ready, 1'b1);
        step();
        check("bp_no_spurious_accept", busy, 1'b0);

        // Asynchronous reset mid-calculation.
        accept(32'h0000_0001);
        for (int i = 0; i < 20; i++) step();
        check("mid_calc_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_out_data", out_data, 38'h0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 45; i++) step();
        check("arst_no_output", out_valid, 1'b0);
        run_directed("post_rst", 32'h0000_0001, 38'h00_0000_0007);

        // Loopback through a correction model, with optional single-bit flips.
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] d;
            d = $urandom;
            exp = model(d);
            accept(d);
            wait_valid(cyc);
            check("loop_data", out_data, exp);
            check("loop_syndrome", syndrome(out_data), 6'd0);
            if (i % 2 == 1) begin
                fpos    = $urandom_range(1, 38);
                flipped = out_data ^ (38'd1 << (fpos - 1));
                s       = syndrome(flipped);
                check("loop_flip_syndrome", s, fpos[5:0]);
                corrected = flipped;
                if (s != 6'd0 && s <= 6'd38) corrected[s - 6'd1] = ~corrected[s - 6'd1];
                check("loop_corrected", corrected, exp);
            end
        end
        out_ready = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
